// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared widths, state encoding and request types for sram_arbiter
//
// Purpose: single home for the SRAM geometry and arbiter types.
//   ADDR_W       byte address width, matches the SRAM
//   DATA_W       line width in bits
//   MASK_W       full-line byte mask width (DATA_W/8)
//   SRAM_MASK_W  byte mask width actually driven to the 16-byte-wide SRAM
package sram_arb_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 512;
  localparam int MASK_W      = DATA_W / 8;
  localparam int SRAM_MASK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef logic port_id_t;

  typedef struct packed {
    logic                   we;
    logic [SRAM_MASK_W-1:0] mask;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      wdata;
  } req_t;

endpackage

// File: rtl/sram_arb_if.sv
// rtl/sram_arb_if.sv - one requester port of sram_arbiter (request and response channels)
//
// Purpose: bundles a requester's valid/ready request channel and its
// valid/ready response channel.
//   req_valid/req_ready  request handshake
//   req_we               1 = write, 0 = read
//   req_mask             byte write mask (ignored for reads)
//   req_addr             base byte address
//   req_wdata            write line
//   resp_valid/ready     response handshake
//   resp_rdata           read line, 0 for write responses
// Modports: master = requester side, slave = arbiter side.
interface sram_arb_if;
  import sram_arb_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [SRAM_MASK_W-1:0] req_mask;
  logic [ADDR_W-1:0]      req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DATA_W-1:0]      resp_rdata;

  modport master (
    output req_valid, req_we, req_mask, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_mask, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational grant selection between the two requesters
//
// Purpose: picks which valid requester is granted in IDLE.
// Ports:
//   p0_valid_i, p1_valid_i  request valids
//   last_grant_i            port granted last (only with SRAM_ARB_RR_EN)
//   grant_valid_o           some port is requesting
//   grant_id_o              granted port id
// Macro SRAM_ARB_RR_EN: defined = round-robin on ties, undefined = port 0 wins ties.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic     p0_valid_i,
  input  logic     p1_valid_i,
`ifdef SRAM_ARB_RR_EN
  input  port_id_t last_grant_i,
`endif
  output logic     grant_valid_o,
  output port_id_t grant_id_o
);

  always_comb begin
    grant_valid_o = p0_valid_i | p1_valid_i;
    grant_id_o    = 1'b0;
    if (p0_valid_i && p1_valid_i) begin
`ifdef SRAM_ARB_RR_EN
      grant_id_o = ~last_grant_i;
`else
      grant_id_o = 1'b0;
`endif
    end else if (p1_valid_i) begin
      grant_id_o = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and sequencer in front of the single-port SRAM
//
// Purpose: accepts one full-line read/write at a time from two requesters,
// performs it on the SRAM in a single BUSY cycle and returns a registered
// response to the requester that issued it.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   p0, p1           requester ports (sram_arb_if.slave), p0 fetch side, p1 data/DMA side
//   sram_w_en        SRAM write enable, only in BUSY for writes and never while rst = 1
//   sram_w_mask      SRAM byte mask (latched request mask)
//   sram_address     SRAM byte address (latched request address)
//   sram_write_data  SRAM write data (latched request data)
//   sram_read_data   SRAM combinational read data
// Macro SRAM_ARB_RR_EN: round-robin tie breaking with a last_grant register;
// undefined gives fixed priority to port 0.
module sram_arbiter
  import sram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  sram_arb_if.slave              p0,
  sram_arb_if.slave              p1,
  output logic                   sram_w_en,
  output logic [SRAM_MASK_W-1:0] sram_w_mask,
  output logic [ADDR_W-1:0]      sram_address,
  output logic [DATA_W-1:0]      sram_write_data,
  input  logic [DATA_W-1:0]      sram_read_data
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]        state_q, state_d;
  port_id_t          pid_q, pid_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] resp_q, resp_d;

  logic              grant_valid;
  port_id_t          grant_id;
  logic              idle;
  logic              accept;
  logic              resp_hs;

`ifdef SRAM_ARB_RR_EN
  port_id_t          last_grant_q, last_grant_d;
`endif

  sram_arb_pick u_pick (
    .p0_valid_i    (p0.req_valid),
    .p1_valid_i    (p1.req_valid),
`ifdef SRAM_ARB_RR_EN
    .last_grant_i  (last_grant_q),
`endif
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // Ready is masked by rst so nothing is accepted on a reset edge.
  assign idle        = (state_q == ST_IDLE) && !rst;
  assign p0.req_ready = idle && grant_valid && (grant_id == 1'b0);
  assign p1.req_ready = idle && grant_valid && (grant_id == 1'b1);
  // The picker only grants a port whose valid is high, so grant_valid is the handshake.
  assign accept      = idle && grant_valid;
  assign resp_hs     = pid_q ? p1.resp_ready : p0.resp_ready;

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    req_d   = req_q;
    resp_d  = resp_q;
`ifdef SRAM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pid_d = grant_id;
          if (grant_id) begin
            req_d.we    = p1.req_we;
            req_d.mask  = p1.req_mask;
            req_d.addr  = p1.req_addr;
            req_d.wdata = p1.req_wdata;
          end else begin
            req_d.we    = p0.req_we;
            req_d.mask  = p0.req_mask;
            req_d.addr  = p0.req_addr;
            req_d.wdata = p0.req_wdata;
          end
`ifdef SRAM_ARB_RR_EN
          last_grant_d = grant_id;
`endif
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A write commits at this same edge; its response carries no data.
        resp_d  = req_q.we ? '0 : sram_read_data;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pid_q   <= 1'b0;
      req_q   <= '0;
      resp_q  <= '0;
`ifdef SRAM_ARB_RR_EN
      // Port 0 wins the first tie after reset.
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
`ifdef SRAM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Address, mask and data always show the latched request so the
  // combinational SRAM read path stays stable outside BUSY.
  assign sram_w_en       = (state_q == ST_BUSY) && req_q.we && !rst;
  assign sram_w_mask     = req_q.mask;
  assign sram_address    = req_q.addr;
  assign sram_write_data = req_q.wdata;

  assign p0.resp_valid = (state_q == ST_RESP) && (pid_q == 1'b0);
  assign p1.resp_valid = (state_q == ST_RESP) && (pid_q == 1'b1);
  assign p0.resp_rdata = resp_q;
  assign p1.resp_rdata = resp_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   clr_mem = 1'b1;
  logic                   sram_w_en;
  logic [SRAM_MASK_W-1:0] sram_w_mask;
  logic [ADDR_W-1:0]      sram_address;
  logic [DATA_W-1:0]      sram_write_data;
  logic [DATA_W-1:0]      sram_read_data;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;

  logic [7:0] mem [0:65535];

  sram_arb_if p0_if ();
  sram_arb_if p1_if ();

  sram_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .p0              (p0_if),
    .p1              (p1_if),
    .sram_w_en       (sram_w_en),
    .sram_w_mask     (sram_w_mask),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data)
  );

  always #5 clk = ~clk;

  // 16-byte-wide byte-addressed SRAM; addresses wrap at 0xFFFF.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    end else if (sram_w_en) begin
      wr_cnt <= wr_cnt + 1;
      for (int i = 0; i < 16; i++)
        if (sram_w_mask[i]) mem[16'(sram_address + 16'(i))] <= sram_write_data[i*8 +: 8];
    end
  end

  always_comb begin
    sram_read_data = '0;
    for (int i = 0; i < 16; i++)
      sram_read_data[i*8 +: 8] = mem[16'(sram_address + 16'(i))];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 1) ? p1_if.req_ready : p0_if.req_ready;
  endfunction

  function automatic logic rv(input int p);
    return (p == 1) ? p1_if.resp_valid : p0_if.resp_valid;
  endfunction

  function automatic logic [DATA_W-1:0] rd(input int p);
    return (p == 1) ? p1_if.resp_rdata : p0_if.resp_rdata;
  endfunction

  task automatic drive(input int p, input logic v, input logic we, input logic [15:0] m,
                       input logic [15:0] a, input logic [DATA_W-1:0] d);
    if (p == 1) begin
      p1_if.req_valid = v; p1_if.req_we = we; p1_if.req_mask = m;
      p1_if.req_addr = a; p1_if.req_wdata = d;
    end else begin
      p0_if.req_valid = v; p0_if.req_we = we; p0_if.req_mask = m;
      p0_if.req_addr = a; p0_if.req_wdata = d;
    end
  endtask

  task automatic wait_ready(input int p, input string tag);
    int n;
    #1;
    n = 0;
    while (!rdy(p) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk1({tag, "_ready"}, rdy(p), 1'b1);
  endtask

  // One complete transaction with resp_ready held high; checks T+1/T+2 latency.
  task automatic txn(input int p, input logic we, input logic [15:0] m, input logic [15:0] a,
                     input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd, input string tag);
    @(negedge clk);
    drive(p, 1'b1, we, m, a, d);
    wait_ready(p, tag);
    @(posedge clk);
    @(negedge clk);
    drive(p, 1'b0, 1'b0, 16'h0, 16'h0, '0);
    #1;
    chk1({tag, "_busy_rv"}, rv(p), 1'b0);
    @(negedge clk);
    #1;
    chk1({tag, "_rv"}, rv(p), 1'b1);
    chk1({tag, "_other_rv"}, rv(1 - p), 1'b0);
    chkw({tag, "_rdata"}, rd(p), exp_rd);
    @(posedge clk);
  endtask

  initial begin
    logic [DATA_W-1:0] pat_a, pat_ff, exp_ff, p30_old, p30_new, wrap_d, wrap_lo;
    int exp_seq [4];
    int left0, left1, gid, n, c0;

    pat_a   = '0; pat_a[127:0]   = {16{8'hA5}};
    pat_ff  = '0; pat_ff[127:0]  = {16{8'hFF}};
    exp_ff  = '0; exp_ff[7:0]    = 8'hFF;
    p30_old = '0; p30_old[127:0] = {16{8'h3C}};
    p30_new = '0; p30_new[127:0] = {16{8'hC3}};
    wrap_d  = '0;
    wrap_lo = '0;
    for (int i = 0; i < 16; i++) wrap_d[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 8; i++) wrap_lo[i*8 +: 8] = 8'(8'h18 + i);
`ifdef SRAM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 1, 1};
`endif

    drive(0, 1'b1, 1'b0, 16'h0, 16'h0, '0);
    drive(1, 1'b1, 1'b0, 16'h0, 16'h0, '0);
    p0_if.resp_ready = 1'b1;
    p1_if.resp_ready = 1'b1;

    // Reset state, with both valids high to show ready is forced low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk1("rst_p0_ready", p0_if.req_ready, 1'b0);
    chk1("rst_p1_ready", p1_if.req_ready, 1'b0);
    chk1("rst_w_en", sram_w_en, 1'b0);
    chk1("rst_p0_rv", p0_if.resp_valid, 1'b0);
    chk1("rst_p1_rv", p1_if.resp_valid, 1'b0);
    chkw("rst_p0_rdata", p0_if.resp_rdata, '0);
    chk_int("rst_addr", int'(sram_address), 0);
    chk_int("rst_state", int'(dut.state_q), 0);
    rst = 1'b0;
    clr_mem = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, '0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, '0);

    // Tie break: both ports hold valid for two reads each.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0, 16'h0010, '0);
    drive(1, 1'b1, 1'b0, 16'h0, 16'h0020, '0);
    left0 = 2;
    left1 = 2;
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (!p0_if.req_ready && !p1_if.req_ready && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk1($sformatf("tie_any_ready%0d", k), p0_if.req_ready | p1_if.req_ready, 1'b1);
      chk1($sformatf("tie_one_ready%0d", k), p0_if.req_ready & p1_if.req_ready, 1'b0);
      gid = p1_if.req_ready ? 1 : 0;
      chk_int($sformatf("tie_grant%0d", k), gid, exp_seq[k]);
      @(posedge clk);
      @(negedge clk);
      if (gid == 0) begin
        left0--;
        if (left0 <= 0) drive(0, 1'b0, 1'b0, 16'h0, 16'h0, '0);
      end else begin
        left1--;
        if (left1 <= 0) drive(1, 1'b0, 1'b0, 16'h0, 16'h0, '0);
      end
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, '0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, '0);
    repeat (3) @(negedge clk);

    // Full-line write and read-back on port 0.
    txn(0, 1'b1, 16'hFFFF, 16'h0010, pat_a, '0, "p0_wr10");
    txn(0, 1'b0, 16'h0000, 16'h0010, '0, pat_a, "p0_rd10");

    // Partial mask: only byte 0 is written.
    txn(1, 1'b1, 16'h0001, 16'h0020, pat_ff, '0, "p1_wr20_m1");
    txn(1, 1'b0, 16'h0000, 16'h0020, '0, exp_ff, "p1_rd20");

    // Response backpressure on port 1 while port 0 waits.
    @(negedge clk);
    p1_if.resp_ready = 1'b0;
    drive(1, 1'b1, 1'b0, 16'h0, 16'h0010, '0);
    wait_ready(1, "bp_acc");
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, '0);
    drive(0, 1'b1, 1'b0, 16'h0, 16'h0020, '0);
    @(negedge clk);
    c0 = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk1($sformatf("bp_rv%0d", k), p1_if.resp_valid, 1'b1);
      chkw($sformatf("bp_rdata%0d", k), p1_if.resp_rdata, pat_a);
      chk1($sformatf("bp_p0_ready%0d", k), p0_if.req_ready, 1'b0);
      chk1($sformatf("bp_p1_ready%0d", k), p1_if.req_ready, 1'b0);
      chk1($sformatf("bp_p0_rv%0d", k), p0_if.resp_valid, 1'b0);
      chk1($sformatf("bp_w_en%0d", k), sram_w_en, 1'b0);
      @(negedge clk);
    end
    p1_if.resp_ready = 1'b1;
    #1;
    chk_int("bp_no_write", wr_cnt, c0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk1("bp_p0_granted_next", p0_if.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, '0);
    @(negedge clk);
    #1;
    chk1("bp_p0_rv", p0_if.resp_valid, 1'b1);
    chkw("bp_p0_rdata", p0_if.resp_rdata, exp_ff);
    @(posedge clk);

    // Reset during the BUSY cycle of a write.
    txn(0, 1'b1, 16'hFFFF, 16'h0030, p30_old, '0, "wr30_old");
    c0 = wr_cnt;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'hFFFF, 16'h0030, p30_new);
    wait_ready(0, "wr30_new");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, '0);
    #1;
    chk1("rstbusy_w_en", sram_w_en, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_int("rstbusy_state", int'(dut.state_q), 0);
    chk1("rstbusy_p0_rv", p0_if.resp_valid, 1'b0);
    chk1("rstbusy_p1_rv", p1_if.resp_valid, 1'b0);
    chk_int("rstbusy_no_write", wr_cnt, c0);
    txn(0, 1'b0, 16'h0000, 16'h0030, '0, p30_old, "rd30");

    // Wrap past 0xFFFF.
    txn(1, 1'b1, 16'hFFFF, 16'hFFF8, wrap_d, '0, "wr_wrap");
    txn(1, 1'b0, 16'h0000, 16'hFFF8, '0, wrap_d, "rd_wrap");
    txn(0, 1'b0, 16'h0000, 16'h0000, '0, wrap_lo, "rd_0000");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
